// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: walks the PC, pairs opcodes with optional immediates, hands packets to decode.
// Optional FETCH_BOOT_VECTOR_EN: load the start PC from a 2-word vector at RESET_VEC after reset.
module fetch_sequencer #(
  parameter int              PC_W      = 32,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter logic [PC_W-1:0] RESET_VEC = '0,
  parameter int              IMM_BIT   = 2,
  parameter logic [15:0]     NOP_INSTR = 16'h07F8
) (
  input  logic            clk,
  input  logic            rst,
  output logic [PC_W-1:0] imem_addr,
  input  logic [15:0]     imem_data,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [15:0]     out_instr,
  output logic [15:0]     out_imm,
  output logic            out_has_imm,
  output logic [PC_W-1:0] out_pc
);
  typedef enum logic [1:0] {S_OP, S_IMM, S_BOOT_HI, S_BOOT_LO} state_t;

  state_t          r_state;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] r_op_pc;
  logic [15:0]     r_op_hold;
  logic            w_adv;

  // Output register may load when empty or being drained this cycle.
  assign w_adv = !out_valid || out_ready;

`ifdef FETCH_BOOT_VECTOR_EN
  logic [15:0] r_boot_hi;

  always_comb begin
    imem_addr = r_pc;
    if (r_state == S_BOOT_HI)      imem_addr = RESET_VEC;
    else if (r_state == S_BOOT_LO) imem_addr = RESET_VEC + PC_W'(1);
  end
`else
  assign imem_addr = r_pc;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc        <= RESET_PC;
      r_op_pc     <= '0;
      r_op_hold   <= '0;
      out_valid   <= 1'b0;
      out_instr   <= NOP_INSTR;
      out_imm     <= '0;
      out_has_imm <= 1'b0;
      out_pc      <= '0;
`ifdef FETCH_BOOT_VECTOR_EN
      r_boot_hi   <= '0;
      r_state     <= S_BOOT_HI;
`else
      r_state     <= S_OP;
`endif
    end
`ifdef FETCH_BOOT_VECTOR_EN
    // Boot vector load is not interruptible by redirects.
    else if (r_state == S_BOOT_HI) begin
      r_boot_hi <= imem_data;
      r_state   <= S_BOOT_LO;
    end else if (r_state == S_BOOT_LO) begin
      r_pc    <= PC_W'({r_boot_hi, imem_data});
      r_state <= S_OP;
    end
`endif
    else if (redirect_valid) begin
      r_pc      <= redirect_pc;
      r_state   <= S_OP;
      out_valid <= 1'b0;
    end else if (w_adv) begin
      case (r_state)
        S_OP: begin
          r_pc <= r_pc + PC_W'(1);
          if (!imem_data[IMM_BIT]) begin
            out_instr   <= imem_data;
            out_imm     <= '0;
            out_has_imm <= 1'b0;
            out_pc      <= r_pc;
            out_valid   <= 1'b1;
          end else begin
            // Park the opcode; the packet completes once the immediate is read.
            r_op_hold <= imem_data;
            r_op_pc   <= r_pc;
            out_valid <= 1'b0;
            r_state   <= S_IMM;
          end
        end
        S_IMM: begin
          out_instr   <= r_op_hold;
          out_imm     <= imem_data;
          out_has_imm <= 1'b1;
          out_pc      <= r_op_pc;
          out_valid   <= 1'b1;
          r_pc        <= r_pc + PC_W'(1);
          r_state     <= S_OP;
        end
        default: r_state <= S_OP;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed + randomized bench for fetch_sequencer against a packet-stream reference model.
module tb_fetch_sequencer;
  localparam int PC_W = 32;
  localparam logic [15:0] NOP = 16'h07F8;
`ifdef FETCH_BOOT_VECTOR_EN
  localparam logic [PC_W-1:0] START = 32'h40;
  localparam int BOOT_CYC = 2;
`else
  localparam logic [PC_W-1:0] START = 32'h0;
  localparam int BOOT_CYC = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic [PC_W-1:0] imem_addr, redirect_pc, out_pc;
  logic [15:0] imem_data, out_instr, out_imm;
  logic redirect_valid, out_valid, out_ready, out_has_imm;

  logic [15:0] mem [256];
  int checks = 0;
  int errors = 0;
  int n_acc = 0;
  logic [PC_W-1:0] exp_pc;
  logic prev_stall;
  logic [PC_W-1:0] s_pc, s_addr;
  logic [15:0] s_instr, s_imm;
  logic s_has;
  logic [15:0] t1_words [3];

  assign imem_data = mem[imem_addr[7:0]];
  always #5 clk = ~clk;

  fetch_sequencer dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_data(imem_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_imm(out_imm), .out_has_imm(out_has_imm), .out_pc(out_pc)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: scoreboard at negedge, then advance to just after the next posedge.
  task automatic cycle();
    logic [15:0] ei, eimm;
    logic eh;
    @(negedge clk);
    if (prev_stall) begin
      chk("stall_pc", out_pc, s_pc);
      chk("stall_instr", out_instr, s_instr);
      chk("stall_imm", out_imm, s_imm);
      chk("stall_has", out_has_imm, s_has);
      chk("stall_addr", imem_addr, s_addr);
      chk("stall_valid", out_valid, 1);
    end
    if (out_valid && out_ready) begin
      ei   = mem[exp_pc[7:0]];
      eh   = ei[2];
      eimm = eh ? mem[exp_pc[7:0] + 8'd1] : 16'h0;
      chk("sb_pc", out_pc, exp_pc);
      chk("sb_instr", out_instr, ei);
      chk("sb_imm", out_imm, eimm);
      chk("sb_has", out_has_imm, eh);
      exp_pc = exp_pc + (eh ? 32'd2 : 32'd1);
      n_acc++;
    end
    prev_stall = out_valid && !out_ready && !redirect_valid;
    s_pc = out_pc; s_instr = out_instr; s_imm = out_imm; s_has = out_has_imm; s_addr = imem_addr;
    if (redirect_valid) exp_pc = redirect_pc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    t1_words[0] = 16'h1000; t1_words[1] = 16'h2008; t1_words[2] = 16'h3010;
    for (int i = 0; i < 3; i++) mem[START[7:0] + 8'(i)] = t1_words[i];
`ifdef FETCH_BOOT_VECTOR_EN
    mem[0] = 16'h0000; mem[1] = 16'h0040;
`endif
    mem[5] = 16'h0004; mem[6] = 16'hBEEF;
    mem[7] = 16'h1111; mem[8] = 16'h2220; mem[9] = 16'h3330;
    mem[20] = 16'h1230;

    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b1;
    prev_stall = 1'b0; exp_pc = START;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_instr", out_instr, NOP);
    chk("rst_imm", out_imm, 0);
    chk("rst_has", out_has_imm, 0);
    chk("rst_pc", out_pc, 0);
    chk("rst_addr", imem_addr, 0);
    rst = 1'b0;

    // Test 1 (and boot vector when enabled)
    for (int i = 0; i < BOOT_CYC; i++) begin
      chk("boot_valid_low", out_valid, 0);
      cycle();
    end
    chk("t1_pre_valid", out_valid, 0);
    cycle();
    for (int i = 0; i < 3; i++) begin
      chk("t1_valid", out_valid, 1);
      chk("t1_pc", out_pc, START + PC_W'(i));
      chk("t1_instr", out_instr, t1_words[i]);
      chk("t1_has", out_has_imm, 0);
      if (i == 2) begin redirect_valid = 1'b1; redirect_pc = 32'd5; end
      cycle();
    end
    redirect_valid = 1'b0;

    // Test 2: two-word instruction
    chk("t2_valid0", out_valid, 0);
    chk("t2_addr0", imem_addr, 5);
    cycle();
    chk("t2_valid1", out_valid, 0);
    chk("t2_addr1", imem_addr, 6);
    cycle();
    chk("t2_valid", out_valid, 1);
    chk("t2_instr", out_instr, 16'h0004);
    chk("t2_imm", out_imm, 16'hBEEF);
    chk("t2_has", out_has_imm, 1);
    chk("t2_pc", out_pc, 5);
    cycle();
    chk("t2_next_pc", out_pc, 7);

    // Test 3: stall for 3 cycles
    out_ready = 1'b0;
    repeat (3) begin
      cycle();
      chk("t3_addr", imem_addr, 8);
    end
    out_ready = 1'b1;
    cycle();
    chk("t3_resume_pc", out_pc, 8);
    cycle();
    chk("t3_resume_pc2", out_pc, 9);

    // Test 4: redirect while an opcode is held
    redirect_valid = 1'b1; redirect_pc = 32'd5;
    cycle();
    redirect_valid = 1'b0;
    cycle();
    chk("t4_in_imm_addr", imem_addr, 6);
    redirect_valid = 1'b1; redirect_pc = 32'd20;
    cycle();
    redirect_valid = 1'b0;
    chk("t4_flush_valid", out_valid, 0);
    chk("t4_addr", imem_addr, 20);
    cycle();
    chk("t4_valid", out_valid, 1);
    chk("t4_pc", out_pc, 20);
    chk("t4_has", out_has_imm, 0);

    // Test 5: redirect beats stall
    out_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'd40;
    cycle();
    redirect_valid = 1'b0; out_ready = 1'b1;
    chk("t5_valid", out_valid, 0);
    chk("t5_addr", imem_addr, 40);

    // Randomized traffic
    n_acc = 0;
    for (int i = 0; i < 600; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc = PC_W'($urandom_range(0, 200));
      cycle();
    end
    redirect_valid = 1'b0;
    chk("rand_progress", (n_acc > 100), 1);

    // Asynchronous reset mid-stream, no clock edge involved
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_instr", out_instr, NOP);
    chk("arst_has", out_has_imm, 0);
    chk("arst_addr", imem_addr, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
